exec_ctrl_unit: RTL and testbench
=================================

# exec_ctrl_unit

Execute-and-decode core of the 8-bit single-cycle CPU. It decodes the 32-bit instruction into datapath and memory-control signals, builds the second ALU operand (immediate, register, or two's-complement of the register), and computes the 8-bit ALU result and ZERO flag. It sits between the register file read ports and the PC/branch logic, register write-back mux and data memory. A small FSM sequences the data-memory READ/WRITE request against BUSYWAIT.

## Interface
- Parameters: none; datapath fixed at 8 bits, instruction at 32 bits.
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- INSTRUCTION  in  32  [31:24] opcode, [18:16] rd, [10:8] rs1, [2:0] rs2, [7:0] immediate, [23:16] branch offset (consumed outside).
- REGOUT1  in  8  register file port 1 (rs1); ALU operand 1.
- REGOUT2  in  8  register file port 2 (rs2).
- BUSYWAIT  in  1  data memory busy.
- ALURESULT  out  8  ALU result; also the data-memory address.
- ZERO  out  1  1 when ALURESULT == 0.
- WRITEENABLE  out  1  register file write request (qualified with !BUSYWAIT outside).
- SELECT4  out  1  write-back source: 0 ALU, 1 memory read data.
- JSIGNAL, BEQSIGNAL, BNESIGNAL  out  1 each  jump / branch-if-equal / branch-if-not-equal.
- READ, WRITE  out  1 each  data memory requests.

## Operation
- Operand 2: NEG = (~REGOUT2)+1 mod 256 (NEG(0x00)=0x00, NEG(0x80)=0x80); REGSEL = NEG if SUB else REGOUT2; OP2 = INSTRUCTION[7:0] if IMM else REGSEL.
- ALUOP: 000 FORWARD (OP2), 001 ADD (REGOUT1+OP2, carry dropped), 010 AND, 011 OR; 1xx yields 0x00.
- Decode (opcode: ALUOP, IMM, SUB, WE, SELECT4, other asserted):
- 0x00 loadi: 000, 1, 0, 1, 0.
- 0x01 mov: 000, 0, 0, 1, 0.
- 0x02 add: 001, 0, 0, 1, 0.
- 0x03 sub: 001, 0, 1, 1, 0.
- 0x04 and: 010, 0, 0, 1, 0; 0x05 or: 011, 0, 0, 1, 0.
- 0x06 j: WE 0, JSIGNAL.
- 0x07 beq / 0x08 bne: 001, 0, 1, WE 0, BEQSIGNAL / BNESIGNAL.
- 0x09 lwd: 000, 0, 0, 1, 1, READ; 0x0A lwi: 000, 1, 0, 1, 1, READ.
- 0x0B swd: 000, 0, 0, WE 0, WRITE (address REGOUT2); 0x0C swi: 000, 1, 0, WE 0, WRITE.
- Any other opcode: all outputs 0, ALUOP 000, no memory request.
- Memory FSM, states IDLE and WAIT:
- IDLE: READ/WRITE follow decode. At posedge, if READ|WRITE and BUSYWAIT=1, go to WAIT.
- WAIT: READ/WRITE = decode AND BUSYWAIT, so the request drops combinationally when BUSYWAIT falls, preventing re-trigger before the PC advances. At posedge with BUSYWAIT=0, go to IDLE.
- While RESET=0, all control outputs (WRITEENABLE, SELECT4, J/BEQ/BNE, READ, WRITE) are forced to 0 and the FSM is held in IDLE. ALURESULT/ZERO stay combinational.

## Timing
- Decode, operand mux, ALU and ZERO are purely combinational, with zero latency from INSTRUCTION/REGOUT changes.
- The FSM is the only state; it updates on posedge CLK and clears asynchronously on RESET falling.
- A load or store occupies cycles until the posedge sampling BUSYWAIT=0. The PC advances at that same edge (outside this block).
- BUSYWAIT=0 at the first edge (zero-wait memory): FSM stays IDLE; the request lasts one cycle.
- RESET asserted during WAIT: FSM returns to IDLE immediately; READ/WRITE go to 0.
- A new memory instruction arriving in IDLE immediately after a WAIT→IDLE transition issues a fresh request.

## Structure
- Shared package: opcode constants 0x00–0x0C, ALUOP encodings, FSM state enum.
- One sub-module `exec_alu`: complementer, the two operand muxes, ALU and ZERO.
- Decode and memory FSM live in the top level.

## Test plan
- loadi, imm 0xAB → ALURESULT 0xAB, WRITEENABLE 1, SELECT4 0. add, R1=0x05, R2=0x03 → 0x08, ZERO 0. add 0xFF+0x01 → 0x00, ZERO 1.
- sub 0x05−0x05 → 0x00, ZERO 1. beq, equal operands → BEQSIGNAL 1, WRITEENABLE 0, ZERO 1. bne 0x07 vs 0x05 → BNESIGNAL 1, ZERO 0.
- and 0xF0/0x3C → 0x30. or → 0xFC. mov R2=0x80 → 0x80. Undefined opcode 0xFF → all controls 0.
- lwd, R2=0x10: READ 1, ALURESULT 0x10, SELECT4 1. BUSYWAIT high for 3 edges → FSM in WAIT, READ held. BUSYWAIT falls mid-cycle → READ 0 before the next edge; FSM returns to IDLE.
- swi, imm 0x22 with the same BUSYWAIT handshake → WRITE high until BUSYWAIT falls. Assert RESET=0 during WAIT → READ/WRITE 0 immediately, FSM IDLE.

Source files
------------

// File: rtl/exec_ctrl_unit_pkg.sv
// Shared definitions for the execute/decode core: opcodes, ALU operation codes
// and the data-memory handshake FSM states.
package exec_ctrl_unit_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_BNE   = 8'h08;
  localparam logic [7:0] OP_LWD   = 8'h09;
  localparam logic [7:0] OP_LWI   = 8'h0A;
  localparam logic [7:0] OP_SWD   = 8'h0B;
  localparam logic [7:0] OP_SWI   = 8'h0C;

  typedef enum logic [2:0] {
    ALU_FWD = 3'b000,
    ALU_ADD = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011
  } alu_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/exec_ctrl_unit_alu.sv
// Operand-2 construction (immediate / register / negated register), 8-bit ALU
// and zero detect. Purely combinational.
module exec_alu
  import exec_ctrl_unit_pkg::*;
(
  input  logic [7:0] regout1,
  input  logic [7:0] regout2,
  input  logic [7:0] imm,
  input  logic [2:0] alu_op,
  input  logic       imm_sel,
  input  logic       sub_sel,
  output logic [7:0] result,
  output logic       zero
);

  logic [7:0] neg;
  logic [7:0] reg_sel;
  logic [7:0] op2;

  assign neg     = (~regout2) + 8'd1;
  assign reg_sel = sub_sel ? neg : regout2;
  assign op2     = imm_sel ? imm : reg_sel;

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_FWD: result = op2;
      ALU_ADD: result = regout1 + op2;
      ALU_AND: result = regout1 & op2;
      ALU_OR:  result = regout1 | op2;
      default: result = '0;
    endcase
  end

  assign zero = (result == 8'h00);

endmodule

// File: rtl/exec_ctrl_unit.sv
// Execute/decode core of the 8-bit single-cycle CPU: instruction decode, ALU
// instance and the FSM that holds data-memory requests against BUSYWAIT.
module exec_ctrl_unit
  import exec_ctrl_unit_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic [7:0]  REGOUT1,
  input  logic [7:0]  REGOUT2,
  input  logic        BUSYWAIT,
  output logic [7:0]  ALURESULT,
  output logic        ZERO,
  output logic        WRITEENABLE,
  output logic        SELECT4,
  output logic        JSIGNAL,
  output logic        BEQSIGNAL,
  output logic        BNESIGNAL,
  output logic        READ,
  output logic        WRITE
);

  logic [7:0] opcode;
  logic [2:0] alu_op;
  logic       imm_sel, sub_sel;
  logic       dec_we, dec_sel4, dec_j, dec_beq, dec_bne, dec_read, dec_write;
  logic       unused_bits;
  mem_state_t state, state_next;

  assign opcode      = INSTRUCTION[31:24];
  assign unused_bits = ^INSTRUCTION[23:8];

  always_comb begin
    alu_op    = ALU_FWD;
    imm_sel   = 1'b0;
    sub_sel   = 1'b0;
    dec_we    = 1'b0;
    dec_sel4  = 1'b0;
    dec_j     = 1'b0;
    dec_beq   = 1'b0;
    dec_bne   = 1'b0;
    dec_read  = 1'b0;
    dec_write = 1'b0;
    case (opcode)
      OP_LOADI: begin imm_sel = 1'b1; dec_we = 1'b1; end
      OP_MOV:   dec_we = 1'b1;
      OP_ADD:   begin alu_op = ALU_ADD; dec_we = 1'b1; end
      OP_SUB:   begin alu_op = ALU_ADD; sub_sel = 1'b1; dec_we = 1'b1; end
      OP_AND:   begin alu_op = ALU_AND; dec_we = 1'b1; end
      OP_OR:    begin alu_op = ALU_OR;  dec_we = 1'b1; end
      OP_J:     dec_j = 1'b1;
      OP_BEQ:   begin alu_op = ALU_ADD; sub_sel = 1'b1; dec_beq = 1'b1; end
      OP_BNE:   begin alu_op = ALU_ADD; sub_sel = 1'b1; dec_bne = 1'b1; end
      OP_LWD:   begin dec_we = 1'b1; dec_sel4 = 1'b1; dec_read = 1'b1; end
      OP_LWI:   begin imm_sel = 1'b1; dec_we = 1'b1; dec_sel4 = 1'b1; dec_read = 1'b1; end
      OP_SWD:   dec_write = 1'b1;
      OP_SWI:   begin imm_sel = 1'b1; dec_write = 1'b1; end
      default:  ;
    endcase
  end

  exec_alu u_alu (
    .regout1 (REGOUT1),
    .regout2 (REGOUT2),
    .imm     (INSTRUCTION[7:0]),
    .alu_op  (alu_op),
    .imm_sel (imm_sel),
    .sub_sel (sub_sel),
    .result  (ALURESULT),
    .zero    (ZERO)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= ST_IDLE;
    else        state <= state_next;
  end

  // In WAIT the request is gated by BUSYWAIT so it drops as soon as memory
  // finishes, before the PC advances and could re-trigger it.
  always_comb begin
    state_next = state;
    READ       = 1'b0;
    WRITE      = 1'b0;
    case (state)
      ST_IDLE: begin
        READ  = dec_read;
        WRITE = dec_write;
        if ((dec_read || dec_write) && BUSYWAIT) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        READ  = dec_read  && BUSYWAIT;
        WRITE = dec_write && BUSYWAIT;
        if (!BUSYWAIT) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (!RESET) begin
      READ       = 1'b0;
      WRITE      = 1'b0;
      state_next = ST_IDLE;
    end
  end

  assign WRITEENABLE = RESET && dec_we;
  assign SELECT4     = RESET && dec_sel4;
  assign JSIGNAL     = RESET && dec_j;
  assign BEQSIGNAL   = RESET && dec_beq;
  assign BNESIGNAL   = RESET && dec_bne;

endmodule

// File: tb/tb_exec_ctrl_unit.sv
// Directed self-checking bench for exec_ctrl_unit: decode/ALU vectors plus the
// BUSYWAIT handshake and reset-during-wait behaviour.
module tb_exec_ctrl_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic [7:0]  REGOUT1, REGOUT2;
  logic        BUSYWAIT;
  logic [7:0]  ALURESULT;
  logic        ZERO, WRITEENABLE, SELECT4, JSIGNAL, BEQSIGNAL, BNESIGNAL, READ, WRITE;
  logic [6:0]  ctrl;

  int n_cmp = 0;
  int n_bad = 0;

  exec_ctrl_unit dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .INSTRUCTION (INSTRUCTION),
    .REGOUT1     (REGOUT1),
    .REGOUT2     (REGOUT2),
    .BUSYWAIT    (BUSYWAIT),
    .ALURESULT   (ALURESULT),
    .ZERO        (ZERO),
    .WRITEENABLE (WRITEENABLE),
    .SELECT4     (SELECT4),
    .JSIGNAL     (JSIGNAL),
    .BEQSIGNAL   (BEQSIGNAL),
    .BNESIGNAL   (BNESIGNAL),
    .READ        (READ),
    .WRITE       (WRITE)
  );

  always #5 CLK = ~CLK;

  // {WE, SEL4, J, BEQ, BNE, READ, WRITE}
  assign ctrl = {WRITEENABLE, SELECT4, JSIGNAL, BEQSIGNAL, BNESIGNAL, READ, WRITE};

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] imm);
    return {op, 16'h0000, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [31:0] ins, input logic [7:0] r1, input logic [7:0] r2);
    INSTRUCTION = ins;
    REGOUT1     = r1;
    REGOUT2     = r2;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET = 1'b0; BUSYWAIT = 1'b0;
    apply(mk(8'h00, 8'hAB), 8'h00, 8'h00);
    check("reset_ctrl", 32'(ctrl), 32'h00);
    check("reset_alu", 32'(ALURESULT), 32'hAB);
    #1 RESET = 1'b1;

    apply(mk(8'h00, 8'hAB), 8'h11, 8'h22);
    check("loadi_res", 32'(ALURESULT), 32'hAB);
    check("loadi_ctrl", 32'(ctrl), 32'b1000000);

    apply(mk(8'h02, 8'h00), 8'h05, 8'h03);
    check("add_res", 32'(ALURESULT), 32'h08);
    check("add_zero", 32'(ZERO), 32'h0);
    check("add_ctrl", 32'(ctrl), 32'b1000000);

    apply(mk(8'h02, 8'h00), 8'hFF, 8'h01);
    check("add_wrap_res", 32'(ALURESULT), 32'h00);
    check("add_wrap_zero", 32'(ZERO), 32'h1);

    apply(mk(8'h03, 8'h00), 8'h05, 8'h05);
    check("sub_res", 32'(ALURESULT), 32'h00);
    check("sub_zero", 32'(ZERO), 32'h1);

    apply(mk(8'h03, 8'h00), 8'h01, 8'h80);
    check("sub_neg80", 32'(ALURESULT), 32'h81);
    apply(mk(8'h03, 8'h00), 8'h37, 8'h00);
    check("sub_neg00", 32'(ALURESULT), 32'h37);

    apply(mk(8'h07, 8'h00), 8'h42, 8'h42);
    check("beq_ctrl", 32'(ctrl), 32'b0001000);
    check("beq_zero", 32'(ZERO), 32'h1);

    apply(mk(8'h08, 8'h00), 8'h07, 8'h05);
    check("bne_ctrl", 32'(ctrl), 32'b0000100);
    check("bne_zero", 32'(ZERO), 32'h0);
    check("bne_res", 32'(ALURESULT), 32'h02);

    apply(mk(8'h04, 8'h00), 8'hF0, 8'h3C);
    check("and_res", 32'(ALURESULT), 32'h30);
    apply(mk(8'h05, 8'h00), 8'hF0, 8'h3C);
    check("or_res", 32'(ALURESULT), 32'hFC);
    apply(mk(8'h01, 8'h55), 8'h12, 8'h80);
    check("mov_res", 32'(ALURESULT), 32'h80);
    check("mov_ctrl", 32'(ctrl), 32'b1000000);

    apply(mk(8'h06, 8'h04), 8'h12, 8'h34);
    check("j_ctrl", 32'(ctrl), 32'b0010000);

    apply(mk(8'hFF, 8'h77), 8'h05, 8'h03);
    check("undef_ctrl", 32'(ctrl), 32'h00);
    check("undef_res", 32'(ALURESULT), 32'h03);

    apply(mk(8'h0A, 8'h33), 8'h99, 8'h44);
    check("lwi_res", 32'(ALURESULT), 32'h33);
    check("lwi_ctrl", 32'(ctrl), 32'b1100010);
    apply(mk(8'h0B, 8'h00), 8'h99, 8'h44);
    check("swd_res", 32'(ALURESULT), 32'h44);
    check("swd_ctrl", 32'(ctrl), 32'b0000001);

    // zero-wait load: request stays, no WAIT entered
    @(negedge CLK);
    apply(mk(8'h09, 8'h00), 8'h00, 8'h20);
    @(posedge CLK); #1;
    check("zw_read", 32'(READ), 32'h1);

    // load with three busy edges
    @(negedge CLK);
    BUSYWAIT = 1'b1;
    apply(mk(8'h09, 8'h00), 8'h77, 8'h10);
    check("lwd_res", 32'(ALURESULT), 32'h10);
    check("lwd_ctrl", 32'(ctrl), 32'b1100010);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("lwd_hold", 32'(READ), 32'h1);
    end
    BUSYWAIT = 1'b0;
    #1;
    check("lwd_drop", 32'(READ), 32'h0);
    check("lwd_drop_ctrl", 32'(ctrl), 32'b1100000);
    @(posedge CLK); #1;
    check("lwd_fresh", 32'(READ), 32'h1);

    // store immediate with busy handshake
    @(negedge CLK);
    BUSYWAIT = 1'b1;
    apply(mk(8'h0C, 8'h22), 8'h01, 8'h02);
    check("swi_res", 32'(ALURESULT), 32'h22);
    check("swi_ctrl", 32'(ctrl), 32'b0000001);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      check("swi_hold", 32'(WRITE), 32'h1);
    end
    BUSYWAIT = 1'b0;
    #1;
    check("swi_drop", 32'(WRITE), 32'h0);
    @(posedge CLK); #1;
    check("swi_fresh", 32'(WRITE), 32'h1);

    // reset while waiting
    @(negedge CLK);
    BUSYWAIT = 1'b1;
    @(negedge CLK);
    check("wait_write", 32'(WRITE), 32'h1);
    RESET = 1'b0;
    #1;
    check("rst_wait_ctrl", 32'(ctrl), 32'h00);
    #1;
    BUSYWAIT = 1'b0;
    RESET = 1'b1;
    #1;
    check("rst_idle_write", 32'(WRITE), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
